// File: rtl/fifo_stream_merge.sv
// fifo_stream_merge: round-robin packet merger of NUM_CH buffered input streams into one output stream
//   clk_clk, reset_reset_n (sync, active-low)
//   in_fifo_data/write/send : per-channel input words, in_fifo_afull : per-channel almost-full
//   out_fifo_data/write/send: merged registered output, out_fifo_full : downstream backpressure
//   ovf_sticky/ovf_clear    : per-channel sticky overflow, out_pkt_cnt : emitted packet count
module fifo_stream_merge #(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 256,
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = DEPTH - 4
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  input  logic [NUM_CH*DATA_W-1:0] in_fifo_data,
  input  logic [NUM_CH-1:0]        in_fifo_write,
  input  logic [NUM_CH-1:0]        in_fifo_send,
  output logic [NUM_CH-1:0]        in_fifo_afull,
  output logic [DATA_W-1:0]        out_fifo_data,
  output logic                     out_fifo_write,
  output logic                     out_fifo_send,
  input  logic                     out_fifo_full,
  output logic [NUM_CH-1:0]        ovf_sticky,
  input  logic                     ovf_clear,
  output logic [15:0]              out_pkt_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  typedef enum logic {IDLE, LOCK} state_t;
  state_t          state_q;
  logic [CW-1:0]   grant_q, last_grant_q, sel, idx;
  logic            hit, pop_any;
  logic [NUM_CH-1:0] empty, pop;
  logic [DATA_W:0] head [NUM_CH];
  logic [DATA_W:0] head_sel;
  assign head_sel = head[grant_q];
  assign pop_any  = state_q == LOCK && !out_fifo_full && !empty[grant_q];
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_W:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     cnt_q;
    logic            ovf_q, full, push;
    assign pop[c]           = pop_any && grant_q == CW'(c);
    assign full             = cnt_q == (AW+1)'(DEPTH);
    // a full buffer still takes a word when the head leaves in the same cycle
    assign push             = reset_reset_n && in_fifo_write[c] && (!full || pop[c]);
    assign empty[c]         = cnt_q == '0;
    assign head[c]          = mem_q[rd_q];
    assign in_fifo_afull[c] = cnt_q >= (AW+1)'(AFULL_TH);
    assign ovf_sticky[c]    = ovf_q;
    always_ff @(posedge clk_clk)
      if (push) mem_q[wr_q] <= {in_fifo_send[c], in_fifo_data[c*DATA_W +: DATA_W]};
    always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (push) wr_q <= wr_q + 1'b1;
        if (pop[c]) rd_q <= rd_q + 1'b1;
        cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop[c]);
        // a new drop wins over a simultaneous clear
        ovf_q <= (in_fifo_write[c] && full && !pop[c]) || (ovf_q && !ovf_clear);
      end
    end
  end
  // first nonempty channel after the previous grant, wrapping
  always_comb begin
    hit = 1'b0;
    sel = '0;
    idx = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = CW'((int'(last_grant_q) + i) % NUM_CH);
      if (!hit && !empty[idx]) begin
        hit = 1'b1;
        sel = idx;
      end
    end
  end
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      last_grant_q   <= CW'(NUM_CH - 1);
      out_fifo_write <= 1'b0;
      out_fifo_send  <= 1'b0;
      out_fifo_data  <= '0;
      out_pkt_cnt    <= '0;
    end else begin
      out_fifo_write <= pop_any;
      out_fifo_send  <= pop_any && head_sel[DATA_W];
      if (pop_any) out_fifo_data <= head_sel[DATA_W-1:0];
      if (out_fifo_send) out_pkt_cnt <= out_pkt_cnt + 16'd1;
      if (state_q == IDLE && hit) begin
        state_q <= LOCK;
        grant_q <= sel;
      end else if (state_q == LOCK && pop_any && head_sel[DATA_W]) begin
        state_q      <= IDLE;
        last_grant_q <= grant_q;
      end
    end
  end
endmodule

// File: tb/tb_fifo_stream_merge.sv
// tb_fifo_stream_merge: randomized scoreboard bench for fifo_stream_merge with a cycle-timed packet model
module tb_fifo_stream_merge;
  localparam int NUM_CH = 4, DATA_W = 256, DEPTH = 16, AFULL_TH = DEPTH - 4;
  logic clk = 1'b0, reset_reset_n;
  logic [NUM_CH*DATA_W-1:0] in_fifo_data;
  logic [NUM_CH-1:0] in_fifo_write, in_fifo_send, in_fifo_afull, ovf_sticky;
  logic [DATA_W-1:0] out_fifo_data;
  logic out_fifo_write, out_fifo_send, out_fifo_full, ovf_clear;
  logic [15:0] out_pkt_cnt;

  fifo_stream_merge #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
    .clk_clk(clk), .reset_reset_n(reset_reset_n),
    .in_fifo_data(in_fifo_data), .in_fifo_write(in_fifo_write), .in_fifo_send(in_fifo_send),
    .in_fifo_afull(in_fifo_afull), .out_fifo_data(out_fifo_data), .out_fifo_write(out_fifo_write),
    .out_fifo_send(out_fifo_send), .out_fifo_full(out_fifo_full), .ovf_sticky(ovf_sticky),
    .ovf_clear(ovf_clear), .out_pkt_cnt(out_pkt_cnt));

  always #5 clk = ~clk;

  typedef struct { logic [DATA_W-1:0] d; logic s; int w; } word_t;
  word_t q [NUM_CH][$];
  bit full_at [65536];
  int cyc = 0, checks = 0, errors = 0;
  logic [15:0] exp_cnt = '0;
  bit mon_en = 0, in_pkt = 0;
  int cur = 0, last_g = NUM_CH - 1, p_idle = 0, prev_pop = 0;
  logic [NUM_CH-1:0] open_ch = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at cycle %0d got %0h want %0h", nm, cyc, act, exp_v);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_word();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic int pending();
    int n = int'(in_pkt);
    for (int c = 0; c < NUM_CH; c++) n += q[c].size();
    return n;
  endfunction

  // Monitor: a channel is visible to the arbiter the cycle after its word is written; a packet is
  // chosen round-robin in the first idle cycle a channel is visible, popped from the next cycle on
  // whenever the downstream is not full, and shows up at the output one cycle after its pop.
  always @(negedge clk) begin
    int t, lo, c0, ch, s_cyc, mn;
    if (mon_en) begin
      t = cyc;
      full_at[t] = out_fifo_full;
      chk("pkt_cnt", DATA_W'(out_pkt_cnt), DATA_W'(exp_cnt));
      if (!out_fifo_write) chk("send_without_write", DATA_W'(out_fifo_send), '0);
      else begin
        ch = -1;
        lo = 0;
        if (!in_pkt) begin
          mn = 32'h7fffffff;
          for (int c = 0; c < NUM_CH; c++) if (q[c].size() > 0 && q[c][0].w < mn) mn = q[c][0].w;
          s_cyc = (mn + 1 > p_idle) ? mn + 1 : p_idle;
          for (int i = 1; i <= NUM_CH; i++)
            if (ch < 0 && q[(last_g + i) % NUM_CH].size() > 0 && q[(last_g + i) % NUM_CH][0].w <= s_cyc - 1)
              ch = (last_g + i) % NUM_CH;
          if (ch >= 0) begin
            cur = ch;
            last_g = ch;
            in_pkt = 1;
            lo = s_cyc + 1;
          end
        end else if (q[cur].size() > 0) begin
          ch = cur;
          lo = (q[cur][0].w + 1 > prev_pop + 1) ? q[cur][0].w + 1 : prev_pop + 1;
        end
        if (ch < 0) chk("unexpected_write", DATA_W'(out_fifo_write), '0);
        else begin
          c0 = -1;
          for (int c = lo; c < t; c++) if (c0 < 0 && !full_at[c]) c0 = c;
          chk("word_time", DATA_W'(t), DATA_W'(c0 + 1));
          prev_pop = t - 1;
          chk("data", out_fifo_data, q[cur][0].d);
          chk("send", DATA_W'(out_fifo_send), DATA_W'(q[cur][0].s));
          if (q[cur][0].s) begin
            in_pkt = 0;
            p_idle = t;
            exp_cnt++;
          end
          void'(q[cur].pop_front());
        end
      end
    end
  end

  // one cycle of input; acc marks writes the buffer is expected to keep
  task automatic drive(input logic [NUM_CH-1:0] w, input logic [NUM_CH-1:0] s, input logic [NUM_CH-1:0] acc);
    for (int c = 0; c < NUM_CH; c++) begin
      in_fifo_data[c*DATA_W +: DATA_W] = rnd_word();
      if (w[c] && acc[c]) q[c].push_back('{in_fifo_data[c*DATA_W +: DATA_W], s[c], cyc});
    end
    in_fifo_write = w;
    in_fifo_send = s;
    @(posedge clk);
    #1;
    in_fifo_write = '0;
    in_fifo_send = '0;
  endtask

  task automatic tick();
    drive('0, '0, '0);
  endtask

  task automatic do_reset();
    reset_reset_n = 1'b0;
    in_fifo_write = '0;
    in_fifo_send = '0;
    @(posedge clk);
    #1;
    for (int c = 0; c < NUM_CH; c++) q[c].delete();
    in_pkt = 0;
    last_g = NUM_CH - 1;
    exp_cnt = '0;
    p_idle = cyc;
    mon_en = 1;
    chk("rst_write", DATA_W'(out_fifo_write), '0);
    chk("rst_send", DATA_W'(out_fifo_send), '0);
    chk("rst_data", out_fifo_data, '0);
    chk("rst_ovf", DATA_W'(ovf_sticky), '0);
    chk("rst_pkt_cnt", DATA_W'(out_pkt_cnt), '0);
    chk("rst_afull", DATA_W'(in_fifo_afull), '0);
    reset_reset_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && pending() != 0; i++) tick();
    chk("drain_left", DATA_W'(pending()), '0);
  endtask

  task automatic at_cycle(input int t);
    for (int i = 0; i < 100 && cyc < t; i++) @(negedge clk);
    if (cyc < t) @(negedge clk);
  endtask

  initial begin
    int t0;
    reset_reset_n = 1'b0;
    in_fifo_data = '0;
    in_fifo_write = '0;
    in_fifo_send = '0;
    out_fifo_full = 1'b0;
    ovf_clear = 1'b0;
    do_reset();
    // three-word packet on ch0 straight after reset
    t0 = cyc;
    drive(4'b0001, 4'b0000, 4'b1111);
    drive(4'b0001, 4'b0000, 4'b1111);
    drive(4'b0001, 4'b0001, 4'b1111);
    at_cycle(t0 + 3);
    chk("lat_first_write", DATA_W'(out_fifo_write), DATA_W'(1));
    at_cycle(t0 + 5);
    chk("lat_last_send", DATA_W'(out_fifo_send), DATA_W'(1));
    at_cycle(t0 + 6);
    chk("lat_pkt_cnt", DATA_W'(out_pkt_cnt), DATA_W'(1));
    @(posedge clk);
    #1;
    drain();
    // ch1 packet leaves last grant on ch1, then ch1 and ch2 race
    drive(4'b0010, 4'b0000, 4'b1111);
    drive(4'b0010, 4'b0010, 4'b1111);
    drain();
    drive(4'b0110, 4'b0000, 4'b1111);
    drive(4'b0110, 4'b0110, 4'b1111);
    drain();
    // downstream stall mid-packet
    for (int j = 0; j < 6; j++) drive(4'b0001, j == 5 ? 4'b0001 : 4'b0000, 4'b1111);
    out_fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_write", DATA_W'(out_fifo_write), '0);
    end
    out_fifo_full = 1'b0;
    drain();
    // overflow of ch3 while the output is blocked
    out_fifo_full = 1'b1;
    for (int j = 0; j <= DEPTH; j++) begin
      chk("afull3", DATA_W'(in_fifo_afull[3]), DATA_W'(j >= AFULL_TH));
      drive(4'b1000, j == DEPTH - 1 ? 4'b1000 : 4'b0000, j < DEPTH ? 4'b1000 : 4'b0000);
    end
    chk("ovf_set", DATA_W'(ovf_sticky), DATA_W'(4'b1000));
    ovf_clear = 1'b1;
    drive(4'b1000, 4'b0000, 4'b0000);
    ovf_clear = 1'b0;
    chk("ovf_set_beats_clear", DATA_W'(ovf_sticky), DATA_W'(4'b1000));
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    chk("ovf_cleared", DATA_W'(ovf_sticky), '0);
    out_fifo_full = 1'b0;
    drain();
    // reset in the middle of an unterminated packet, then ch0 must win
    for (int j = 0; j < 4; j++) drive(4'b0010, 4'b0000, 4'b1111);
    tick();
    tick();
    do_reset();
    drive(4'b0101, 4'b0000, 4'b1111);
    drive(4'b0101, 4'b0101, 4'b1111);
    drain();
    // random traffic with flow control through in_fifo_afull
    for (int i = 0; i < 3000; i++) begin
      logic [NUM_CH-1:0] w, s;
      for (int c = 0; c < NUM_CH; c++) begin
        w[c] = $urandom_range(0, 2) == 0 && !in_fifo_afull[c];
        s[c] = $urandom_range(0, 3) == 0;
        if (w[c]) open_ch[c] = !s[c];
      end
      out_fifo_full = $urandom_range(0, 3) == 0;
      drive(w, s, 4'b1111);
    end
    out_fifo_full = 1'b0;
    for (int i = 0; i < 1000 && open_ch != '0; i++) begin
      logic [NUM_CH-1:0] w;
      w = '0;
      for (int c = 0; c < NUM_CH; c++) if (open_ch[c] && !in_fifo_afull[c]) w[c] = 1'b1;
      open_ch &= ~w;
      drive(w, w, 4'b1111);
    end
    chk("close_packets", DATA_W'(open_ch), '0);
    drain();
    chk("ovf_end", DATA_W'(ovf_sticky), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
